bp_be_br_resolve: RTL and testbench
===================================

BP_BE_BR_RESOLVE -- requirements
Module: bp_be_br_resolve

Interface
REQ-001 SHALL have parameter vaddr_width_p, default 39, virtual address width.
REQ-002 SHALL have parameter branch_metadata_fwd_width_p, default 36, width of the opaque frontend metadata.
REQ-003 SHALL have parameter track_els_p, default 4, tracker depth (power of 2, at least 2).
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port reset_i, input, 1, synchronous active-low reset.
REQ-006 SHALL have port fetch_v_i, input, 1, valid for the fetch entry being enqueued.
REQ-007 SHALL have port fetch_ready_o, output, 1, enqueue accept.
REQ-008 SHALL have port fetch_pc_i, input, vaddr_width_p, fetched instruction PC.
REQ-009 SHALL have port fetch_npc_i, input, vaddr_width_p, frontend-predicted next PC.
REQ-010 SHALL have port fetch_pred_taken_i, input, 1, predicted taken.
REQ-011 SHALL have port fetch_ctl_i, input, 1, entry is a branch or jump.
REQ-012 SHALL have port fetch_br_metadata_i, input, branch_metadata_fwd_width_p, opaque metadata.
REQ-013 SHALL have port resolve_v_i, input, 1, execution has resolved the oldest tracked entry.
REQ-014 SHALL have port resolve_taken_i, input, 1, actual direction.
REQ-015 SHALL have port resolve_npc_i, input, vaddr_width_p, actual next PC.
REQ-016 SHALL have port redirect_v_o, output, 1, valid-only redirect pulse.
REQ-017 SHALL have port redirect_pc_o, output, vaddr_width_p, redirect target.
REQ-018 SHALL have port redirect_br_taken_o, output, 1, actual direction.
REQ-019 SHALL have port redirect_br_metadata_o, output, branch_metadata_fwd_width_p, metadata of the mispredicted entry.
REQ-020 SHALL have port attaboy_v_o, output, 1, valid for a correct-prediction report.
REQ-021 SHALL have port attaboy_yumi_i, input, 1, consumer takes the attaboy.
REQ-022 SHALL have port attaboy_br_metadata_o, output, branch_metadata_fwd_width_p, metadata of the correctly predicted entry.
REQ-023 SHALL have port drop_cnt_o, output, 8, saturating count of dropped attaboys.
REQ-024 SHALL have port error_o, output, 1, sticky flag set by resolve on an empty tracker.

Function
REQ-025 Tracker SHALL be an in-order FIFO of track_els_p entries {pc, npc, pred_taken, ctl, metadata}; enqueue on fetch_v_i & fetch_ready_o.
REQ-026 fetch_ready_o SHALL be ~full & ~redirect_v_o, using registered state only; there is no bypass, so a full tracker blocks enqueue even when resolve_v_i pops in the same cycle.
REQ-027 resolve_v_i SHALL pop the head entry.
REQ-028 A mispredict SHALL be detected when (resolve_taken_i != head.pred_taken) or (resolve_npc_i != head.npc).
REQ-029 On mispredict, the next cycle SHALL assert redirect_v_o for exactly 1 cycle with redirect_pc_o=resolve_npc_i, redirect_br_taken_o=resolve_taken_i and redirect_br_metadata_o=head.metadata.
REQ-030 On mispredict, the tracker SHALL be emptied at that clock edge, and any fetch offered in the same cycle SHALL be discarded.
REQ-031 A correct resolution with head.ctl=1 SHALL push head.metadata into a 2-entry attaboy FIFO.
REQ-032 A correct resolution with head.ctl=0 SHALL produce no output.
REQ-033 attaboy_v_o SHALL equal attaboy FIFO non-empty, and attaboy_br_metadata_o SHALL be the FIFO head; attaboy_yumi_i SHALL pop, and is legal only while attaboy_v_o=1.
REQ-034 A push to a full attaboy FIFO with no same-cycle yumi SHALL be dropped, and drop_cnt_o SHALL increment, saturating at 255.
REQ-035 A push to a full attaboy FIFO with a same-cycle yumi SHALL be accepted.
REQ-036 Redirects SHALL NOT flush the attaboy FIFO.
REQ-037 Attaboy pushes SHALL become visible on attaboy_v_o the cycle after the resolve.
REQ-038 resolve_v_i with an empty tracker SHALL be ignored except for setting error_o, which stays set until reset.
REQ-039 FIFO pointers SHALL wrap modulo track_els_p, and full/empty SHALL be distinguished by an extra pointer bit.
REQ-040 redirect_pc_o, redirect_br_taken_o and redirect_br_metadata_o SHALL hold their last value when redirect_v_o=0.

Reset
REQ-041 While reset_i=0 at a clock edge, the block SHALL clear both FIFOs.
REQ-042 Reset SHALL set redirect_v_o=0, attaboy_v_o=0, drop_cnt_o=0, error_o=0 and redirect_pc_o/metadata=0.
REQ-043 fetch_ready_o SHALL be 0 during reset and 1 in the first cycle after reset.
REQ-044 Reset asserted mid-redirect or with pending attaboys SHALL discard all state with no further pulses.

Verification
REQ-045 Enqueue pc=0x1000, npc=0x1004, pred_taken=0, ctl=1, then resolve taken=0, npc=0x1004 -> no redirect, attaboy_v_o=1 the next cycle carrying that metadata, clears on yumi.
REQ-046 Enqueue 3 entries, resolve the head with taken=1, npc=0x2000 against pred npc=0x1004 -> 1-cycle redirect_v_o, pc=0x2000, taken=1, head metadata; tracker empty; fetch_ready_o low during the pulse.
REQ-047 Fill 4 entries, then assert fetch_v_i and resolve_v_i in the same cycle -> fetch not accepted; occupancy becomes 3.
REQ-048 Hold yumi low and make 5 correct ctl resolutions -> 2 attaboys buffered, drop_cnt_o=3; a 6th resolve with a same-cycle yumi -> accepted, drop_cnt_o stays 3.
REQ-049 Resolve on an empty tracker -> error_o=1 persists, no redirect or attaboy; apply reset_i=0 -> error_o=0.
REQ-050 Pull reset_i=0 in the cycle redirect_v_o=1 with 2 attaboys pending -> the next cycle shows all outputs at reset values.

Source files
------------

// File: rtl/bp_be_br_resolve.sv
// Branch resolution tracker: holds in-flight fetch entries in order, compares
// each resolution against its prediction, emits a one-cycle redirect on a
// mispredict and buffers metadata of correctly predicted control transfers
// ("attaboys") in a small FIFO for the frontend predictor.
module bp_be_br_resolve #(
    parameter int vaddr_width_p               = 39,
    parameter int branch_metadata_fwd_width_p = 36,
    parameter int track_els_p                 = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   fetch_v_i,
    output logic                                   fetch_ready_o,
    input  logic [vaddr_width_p-1:0]               fetch_pc_i,
    input  logic [vaddr_width_p-1:0]               fetch_npc_i,
    input  logic                                   fetch_pred_taken_i,
    input  logic                                   fetch_ctl_i,
    input  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata_i,
    input  logic                                   resolve_v_i,
    input  logic                                   resolve_taken_i,
    input  logic [vaddr_width_p-1:0]               resolve_npc_i,
    output logic                                   redirect_v_o,
    output logic [vaddr_width_p-1:0]               redirect_pc_o,
    output logic                                   redirect_br_taken_o,
    output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_o,
    output logic                                   attaboy_v_o,
    input  logic                                   attaboy_yumi_i,
    output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_o,
    output logic [7:0]                             drop_cnt_o,
    output logic                                   error_o
);

    localparam int ptr_w = $clog2(track_els_p);
    localparam logic [ptr_w:0] ptr_one = 1;
    localparam logic [1:0] ab_one = 2'd1;

    // Tracker storage; the extra pointer bit separates full from empty.
    logic [vaddr_width_p-1:0]               pc_mem  [track_els_p];
    logic [vaddr_width_p-1:0]               npc_mem [track_els_p];
    logic                                   pt_mem  [track_els_p];
    logic                                   ctl_mem [track_els_p];
    logic [branch_metadata_fwd_width_p-1:0] md_mem  [track_els_p];
    logic [ptr_w:0] wr_ptr_reg, rd_ptr_reg;

    // Attaboy FIFO: two entries, one index bit plus a wrap bit.
    logic [branch_metadata_fwd_width_p-1:0] ab_mem [2];
    logic [1:0] ab_wr_reg, ab_rd_reg;

    logic                                   redirect_v_reg;
    logic [vaddr_width_p-1:0]               redirect_pc_reg;
    logic                                   redirect_taken_reg;
    logic [branch_metadata_fwd_width_p-1:0] redirect_md_reg;
    logic [7:0]                             drop_cnt_reg;
    logic                                   error_reg;

    logic [ptr_w-1:0] wr_idx, rd_idx;
    logic empty, full, resolve_fire, mispredict, correct, enq;
    logic ab_empty, ab_full, ab_push, ab_pop, ab_accept, ab_drop;

    assign wr_idx = wr_ptr_reg[ptr_w-1:0];
    assign rd_idx = rd_ptr_reg[ptr_w-1:0];
    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_reg[ptr_w] != rd_ptr_reg[ptr_w]);

    // No bypass: readiness depends only on registered state (and reset).
    assign fetch_ready_o = reset_i & ~full & ~redirect_v_reg;

    assign resolve_fire = resolve_v_i & ~empty;
    assign mispredict   = resolve_fire & ((resolve_taken_i != pt_mem[rd_idx])
                                        | (resolve_npc_i != npc_mem[rd_idx]));
    assign correct      = resolve_fire & ~mispredict;
    // A fetch offered alongside a mispredict belongs to the wrong path.
    assign enq          = fetch_v_i & fetch_ready_o & ~mispredict;

    assign ab_empty  = (ab_wr_reg == ab_rd_reg);
    assign ab_full   = (ab_wr_reg[0] == ab_rd_reg[0]) && (ab_wr_reg[1] != ab_rd_reg[1]);
    assign ab_push   = correct & ctl_mem[rd_idx];
    assign ab_pop    = attaboy_yumi_i & ~ab_empty;
    assign ab_accept = ab_push & (~ab_full | ab_pop);
    assign ab_drop   = ab_push & ab_full & ~ab_pop;

    // Per-entry tracker writes; entries are not reset, pointers qualify them.
    generate
        for (genvar gi = 0; gi < track_els_p; gi++) begin : g_track
            always_ff @(posedge clk_i) begin
                if (enq && (wr_idx == ptr_w'(gi))) begin
                    pc_mem[gi]  <= fetch_pc_i;
                    npc_mem[gi] <= fetch_npc_i;
                    pt_mem[gi]  <= fetch_pred_taken_i;
                    ctl_mem[gi] <= fetch_ctl_i;
                    md_mem[gi]  <= fetch_br_metadata_i;
                end
            end
        end
    endgenerate

    // Tracker pointers: a mispredict flushes everything still in flight.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (mispredict) begin
            rd_ptr_reg <= wr_ptr_reg;
        end else begin
            if (enq)          wr_ptr_reg <= wr_ptr_reg + ptr_one;
            if (resolve_fire) rd_ptr_reg <= rd_ptr_reg + ptr_one;
        end
    end

    // Attaboy FIFO data write.
    always_ff @(posedge clk_i) begin
        if (ab_accept) ab_mem[ab_wr_reg[0]] <= md_mem[rd_idx];
    end

    // Attaboy FIFO pointers and saturating drop counter; redirects leave it alone.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            ab_wr_reg    <= '0;
            ab_rd_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (ab_accept) ab_wr_reg <= ab_wr_reg + ab_one;
            if (ab_pop)    ab_rd_reg <= ab_rd_reg + ab_one;
            if (ab_drop && (drop_cnt_reg != 8'hFF)) drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    // Redirect pulse and held payload, plus the sticky empty-resolve error.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            redirect_v_reg     <= 1'b0;
            redirect_pc_reg    <= '0;
            redirect_taken_reg <= 1'b0;
            redirect_md_reg    <= '0;
            error_reg          <= 1'b0;
        end else begin
            redirect_v_reg <= mispredict;
            if (mispredict) begin
                redirect_pc_reg    <= resolve_npc_i;
                redirect_taken_reg <= resolve_taken_i;
                redirect_md_reg    <= md_mem[rd_idx];
            end
            if (resolve_v_i && empty) error_reg <= 1'b1;
        end
    end

    assign redirect_v_o           = redirect_v_reg;
    assign redirect_pc_o          = redirect_pc_reg;
    assign redirect_br_taken_o    = redirect_taken_reg;
    assign redirect_br_metadata_o = redirect_md_reg;
    assign attaboy_v_o            = ~ab_empty;
    assign attaboy_br_metadata_o  = ab_mem[ab_rd_reg[0]];
    assign drop_cnt_o             = drop_cnt_reg;
    assign error_o                = error_reg;

endmodule

// File: tb/tb_bp_be_br_resolve.sv
// Directed bench for bp_be_br_resolve with hand-computed expectations.
module tb_bp_be_br_resolve;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        fetch_v_i = 1'b0;
    logic        fetch_ready_o;
    logic [38:0] fetch_pc_i = '0;
    logic [38:0] fetch_npc_i = '0;
    logic        fetch_pred_taken_i = 1'b0;
    logic        fetch_ctl_i = 1'b0;
    logic [35:0] fetch_br_metadata_i = '0;
    logic        resolve_v_i = 1'b0;
    logic        resolve_taken_i = 1'b0;
    logic [38:0] resolve_npc_i = '0;
    logic        redirect_v_o;
    logic [38:0] redirect_pc_o;
    logic        redirect_br_taken_o;
    logic [35:0] redirect_br_metadata_o;
    logic        attaboy_v_o;
    logic        attaboy_yumi_i = 1'b0;
    logic [35:0] attaboy_br_metadata_o;
    logic [7:0]  drop_cnt_o;
    logic        error_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bp_be_br_resolve dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .fetch_v_i              (fetch_v_i),
        .fetch_ready_o          (fetch_ready_o),
        .fetch_pc_i             (fetch_pc_i),
        .fetch_npc_i            (fetch_npc_i),
        .fetch_pred_taken_i     (fetch_pred_taken_i),
        .fetch_ctl_i            (fetch_ctl_i),
        .fetch_br_metadata_i    (fetch_br_metadata_i),
        .resolve_v_i            (resolve_v_i),
        .resolve_taken_i        (resolve_taken_i),
        .resolve_npc_i          (resolve_npc_i),
        .redirect_v_o           (redirect_v_o),
        .redirect_pc_o          (redirect_pc_o),
        .redirect_br_taken_o    (redirect_br_taken_o),
        .redirect_br_metadata_o (redirect_br_metadata_o),
        .attaboy_v_o            (attaboy_v_o),
        .attaboy_yumi_i         (attaboy_yumi_i),
        .attaboy_br_metadata_o  (attaboy_br_metadata_o),
        .drop_cnt_o             (drop_cnt_o),
        .error_o                (error_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic [38:0] pc, input logic [38:0] npc,
                             input logic pt, input logic ctl, input logic [35:0] md);
        fetch_v_i           = 1'b1;
        fetch_pc_i          = pc;
        fetch_npc_i         = npc;
        fetch_pred_taken_i  = pt;
        fetch_ctl_i         = ctl;
        fetch_br_metadata_i = md;
    endtask

    task automatic enq(input logic [38:0] pc, input logic [38:0] npc,
                       input logic pt, input logic ctl, input logic [35:0] md);
        set_fetch(pc, npc, pt, ctl, md);
        tick();
        fetch_v_i = 1'b0;
    endtask

    task automatic set_resolve(input logic taken, input logic [38:0] npc);
        resolve_v_i     = 1'b1;
        resolve_taken_i = taken;
        resolve_npc_i   = npc;
    endtask

    task automatic resolve(input logic taken, input logic [38:0] npc, input logic yumi);
        set_resolve(taken, npc);
        attaboy_yumi_i = yumi;
        tick();
        resolve_v_i    = 1'b0;
        attaboy_yumi_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
        #1;
    endtask

    initial begin
        // Reset values
        reset_i = 1'b0;
        tick();
        tick();
        check("rst_ready",  64'(fetch_ready_o), 64'd0);
        check("rst_redir",  64'(redirect_v_o),  64'd0);
        check("rst_ab_v",   64'(attaboy_v_o),   64'd0);
        check("rst_drop",   64'(drop_cnt_o),    64'd0);
        check("rst_err",    64'(error_o),       64'd0);
        check("rst_rpc",    64'(redirect_pc_o), 64'd0);
        check("rst_rmd",    64'(redirect_br_metadata_o), 64'd0);
        reset_i = 1'b1;
        #1;
        check("post_rst_ready", 64'(fetch_ready_o), 64'd1);

        // Correct ctl prediction produces an attaboy one cycle later
        enq(39'h1000, 39'h1004, 1'b0, 1'b1, 36'h0A5);
        set_resolve(1'b0, 39'h1004);
        #1;
        check("ab_not_yet", 64'(attaboy_v_o), 64'd0);
        tick();
        resolve_v_i = 1'b0;
        check("ab_no_redir", 64'(redirect_v_o), 64'd0);
        check("ab_v",        64'(attaboy_v_o), 64'd1);
        check("ab_md",       64'(attaboy_br_metadata_o), 64'h0A5);
        attaboy_yumi_i = 1'b1;
        tick();
        attaboy_yumi_i = 1'b0;
        check("ab_cleared", 64'(attaboy_v_o), 64'd0);

        // Mispredict on head of three, with a wrong-path fetch in the same cycle
        enq(39'h1000, 39'h1004, 1'b0, 1'b1, 36'h011);
        enq(39'h1004, 39'h1008, 1'b0, 1'b1, 36'h022);
        enq(39'h1008, 39'h100C, 1'b0, 1'b1, 36'h033);
        set_resolve(1'b1, 39'h2000);
        set_fetch(39'h100C, 39'h1010, 1'b0, 1'b1, 36'h044);
        tick();
        resolve_v_i = 1'b0;
        fetch_v_i   = 1'b0;
        check("mp_redir_v",  64'(redirect_v_o),  64'd1);
        check("mp_redir_pc", 64'(redirect_pc_o), 64'h2000);
        check("mp_taken",    64'(redirect_br_taken_o), 64'd1);
        check("mp_md",       64'(redirect_br_metadata_o), 64'h011);
        check("mp_ready_lo", 64'(fetch_ready_o), 64'd0);
        check("mp_no_ab",    64'(attaboy_v_o),   64'd0);
        tick();
        check("mp_pulse_end", 64'(redirect_v_o), 64'd0);
        check("mp_pc_hold",   64'(redirect_pc_o), 64'h2000);
        check("mp_ready_hi",  64'(fetch_ready_o), 64'd1);

        // Tracker must be empty: three entries leave room, the fourth fills it
        for (int i = 0; i < 3; i++) enq(39'h3000, 39'h3004, 1'b0, 1'b0, 36'(i));
        check("flush_room", 64'(fetch_ready_o), 64'd1);
        enq(39'h3000, 39'h3004, 1'b0, 1'b0, 36'h3);
        check("full_ready", 64'(fetch_ready_o), 64'd0);

        // Full tracker: a fetch with a same-cycle resolve is not accepted
        set_fetch(39'h3000, 39'h3004, 1'b0, 1'b0, 36'h9);
        resolve(1'b0, 39'h3004, 1'b0);
        fetch_v_i = 1'b0;
        check("nobypass_ready", 64'(fetch_ready_o), 64'd1);
        check("nobypass_noab",  64'(attaboy_v_o),   64'd0);
        for (int i = 0; i < 3; i++) resolve(1'b0, 39'h3004, 1'b0);
        check("occ3_no_err", 64'(error_o), 64'd0);

        // Resolve on empty tracker sets a sticky error and nothing else
        resolve(1'b0, 39'h3004, 1'b0);
        check("err_set",   64'(error_o),      64'd1);
        check("err_redir", 64'(redirect_v_o), 64'd0);
        check("err_ab",    64'(attaboy_v_o),  64'd0);
        tick();
        check("err_sticky", 64'(error_o), 64'd1);
        do_reset();
        check("err_cleared", 64'(error_o), 64'd0);

        // Attaboy overflow: five correct resolutions with no yumi
        for (int i = 0; i < 5; i++) begin
            enq(39'h4000, 39'h4004, 1'b0, 1'b1, 36'h100 + 36'(i));
            resolve(1'b0, 39'h4004, 1'b0);
        end
        check("ovf_ab_v", 64'(attaboy_v_o), 64'd1);
        check("ovf_md",   64'(attaboy_br_metadata_o), 64'h100);
        check("ovf_drop", 64'(drop_cnt_o), 64'd3);
        enq(39'h4000, 39'h4004, 1'b0, 1'b1, 36'h105);
        resolve(1'b0, 39'h4004, 1'b1);
        check("yumi_push_drop", 64'(drop_cnt_o), 64'd3);
        check("yumi_push_head", 64'(attaboy_br_metadata_o), 64'h101);
        attaboy_yumi_i = 1'b1;
        tick();
        attaboy_yumi_i = 1'b0;
        check("yumi_push_kept", 64'(attaboy_br_metadata_o), 64'h105);
        enq(39'h4000, 39'h4004, 1'b0, 1'b1, 36'h106);
        resolve(1'b0, 39'h4004, 1'b0);

        // Reset during a redirect pulse with two attaboys pending
        enq(39'h5000, 39'h5004, 1'b0, 1'b1, 36'h077);
        resolve(1'b1, 39'h6000, 1'b0);
        check("pre_rst_redir", 64'(redirect_v_o), 64'd1);
        check("pre_rst_ab",    64'(attaboy_v_o),  64'd1);
        reset_i = 1'b0;
        tick();
        check("mid_rst_redir", 64'(redirect_v_o),  64'd0);
        check("mid_rst_ab",    64'(attaboy_v_o),   64'd0);
        check("mid_rst_drop",  64'(drop_cnt_o),    64'd0);
        check("mid_rst_pc",    64'(redirect_pc_o), 64'd0);
        check("mid_rst_md",    64'(redirect_br_metadata_o), 64'd0);
        check("mid_rst_ready", 64'(fetch_ready_o), 64'd0);
        reset_i = 1'b1;
        tick();
        check("after_rst_redir", 64'(redirect_v_o), 64'd0);
        check("after_rst_ab",    64'(attaboy_v_o),  64'd0);
        check("after_rst_ready", 64'(fetch_ready_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
